// File: rtl/mac_rx_sched_if.sv
// Handshake bundle between the receive scheduler, the PHY FIFO status flags
// and the MAC receive decoder.
`timescale 1ns/1ps

interface mac_rx_sched_if;
    logic [3:0] port_en;
    logic [3:0] req;
    logic       dec_ready;
    logic       dec_done;
    logic       dec_err;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       dec_start;
    logic       dec_abort;
    logic [7:0] err_cnt;
    logic [7:0] tmo_cnt;

    modport master (
        input  port_en, req, dec_ready, dec_done, dec_err,
        output grant_vld, grant_id, dec_start, dec_abort, err_cnt, tmo_cnt
    );

    modport slave (
        output port_en, req, dec_ready, dec_done, dec_err,
        input  grant_vld, grant_id, dec_start, dec_abort, err_cnt, tmo_cnt
    );
endinterface

// File: rtl/mac_rx_sched.sv
// Frame-granular round-robin scheduler sharing one MAC receive decoder among
// four PHY receive FIFOs, with a per-frame watchdog and error/timeout counters.
`timescale 1ns/1ps

module mac_rx_sched #(
    parameter int TMO_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    mac_rx_sched_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_t           state_r;
    state_t           next_state_s;
    logic             grant_vld_r;
    logic             grant_vld_s;
    logic [1:0]       grant_id_r;
    logic [1:0]       grant_id_s;
    logic             dec_start_r;
    logic             dec_start_s;
    logic             dec_abort_r;
    logic             dec_abort_s;
    logic [7:0]       err_cnt_r;
    logic [7:0]       err_cnt_s;
    logic [7:0]       tmo_cnt_r;
    logic [7:0]       tmo_cnt_s;
    logic [1:0]       rr_ptr_r;
    logic [1:0]       rr_ptr_s;
    logic [TMO_W-1:0] timer_r;
    logic [TMO_W-1:0] timer_s;
    logic [3:0]       eff_s;
    logic             eligible_s;
    logic             expired_s;

    // First set bit of eff, scanning circularly starting at ptr.
    function automatic logic [1:0] rr_pick(input logic [3:0] eff, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && eff[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        sat_inc8 = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    assign eff_s      = bus.req & bus.port_en;
    assign eligible_s = bus.dec_ready && (|eff_s);
    assign expired_s  = (timer_r == TMO_MAX);

    // State register and all registered outputs; rst clears everything, no abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_vld_r <= 1'b0;
            grant_id_r  <= 2'd0;
            dec_start_r <= 1'b0;
            dec_abort_r <= 1'b0;
            err_cnt_r   <= 8'd0;
            tmo_cnt_r   <= 8'd0;
            rr_ptr_r    <= 2'd0;
            timer_r     <= '0;
        end else begin
            state_r     <= next_state_s;
            grant_vld_r <= grant_vld_s;
            grant_id_r  <= grant_id_s;
            dec_start_r <= dec_start_s;
            dec_abort_r <= dec_abort_s;
            err_cnt_r   <= err_cnt_s;
            tmo_cnt_r   <= tmo_cnt_s;
            rr_ptr_r    <= rr_ptr_s;
            timer_r     <= timer_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.dec_done || expired_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_GAP:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer, timer and counters.
    always_comb begin
        grant_vld_s = grant_vld_r;
        grant_id_s  = grant_id_r;
        dec_start_s = 1'b0;
        dec_abort_s = 1'b0;
        err_cnt_s   = err_cnt_r;
        tmo_cnt_s   = tmo_cnt_r;
        rr_ptr_s    = rr_ptr_r;
        timer_s     = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (eligible_s) begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = rr_pick(eff_s, rr_ptr_r);
                    dec_start_s = 1'b1;
                    timer_s     = '0;
                end else begin
                    grant_vld_s = grant_vld_r;
                end
            end
            ST_BUSY: begin
                // Completion takes priority over a coincident watchdog expiry.
                if (bus.dec_done) begin
                    grant_vld_s = 1'b0;
                    rr_ptr_s    = grant_id_r + 2'd1;
                    if (bus.dec_err) begin
                        err_cnt_s = sat_inc8(err_cnt_r);
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                end else if (expired_s) begin
                    grant_vld_s = 1'b0;
                    dec_abort_s = 1'b1;
                    tmo_cnt_s   = sat_inc8(tmo_cnt_r);
                    rr_ptr_s    = grant_id_r + 2'd1;
                end else begin
                    timer_s = timer_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP:  grant_vld_s = 1'b0;
            default: grant_vld_s = 1'b0;
        endcase
    end

    assign bus.grant_vld = grant_vld_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.dec_start = dec_start_r;
    assign bus.dec_abort = dec_abort_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.tmo_cnt   = tmo_cnt_r;

endmodule

// File: tb/tb_mac_rx_sched.sv
// Directed self-checking bench for mac_rx_sched, built with a 4-bit watchdog.
`timescale 1ns/1ps

module tb_mac_rx_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mac_rx_sched_if bus();

    mac_rx_sched #(.TMO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.dec_start === 1'b1) seen = 1'b1;
        end
    endtask

    // Wait for a grant, hold it 'hold' cycles, pulse dec_done, then sit out the gap.
    task automatic run_frame(input int hold, output bit seen, output logic [1:0] id);
        wait_start(20, seen);
        id = bus.grant_id;
        repeat (hold) tick();
        bus.dec_done = 1'b1;
        tick();
        bus.dec_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.port_en = 4'd0; bus.req = 4'd0; bus.dec_ready = 1'b0;
        bus.dec_done = 1'b0; bus.dec_err = 1'b0;
        tick(); tick();
        n_checks++; if (bus.grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_grant_vld got=%0d exp=0", bus.grant_vld); end
        n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
        n_checks++; if (bus.dec_start !== 1'b0) begin n_fail++; $display("FAIL reset_dec_start got=%0d exp=0", bus.dec_start); end
        n_checks++; if (bus.dec_abort !== 1'b0) begin n_fail++; $display("FAIL reset_dec_abort got=%0d exp=0", bus.dec_abort); end
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", bus.err_cnt); end
        n_checks++; if (bus.tmo_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_tmo_cnt got=%0d exp=0", bus.tmo_cnt); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.grant_vld !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got=%0d exp=0", bus.grant_vld); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [5];
        int starts;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        starts = 0;
        bus.req = 4'b1111; bus.port_en = 4'b1111; bus.dec_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            tick();
            if (bus.dec_start === 1'b1) starts++;
            n_checks++;
            if (bus.dec_start !== 1'b1 || bus.grant_vld !== 1'b1 || bus.grant_id !== exp_ids[f]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d] got start=%0d vld=%0d id=%0d exp start=1 vld=1 id=%0d",
                         f, bus.dec_start, bus.grant_vld, bus.grant_id, exp_ids[f]);
            end
            for (int c = 0; c < 4; c++) begin
                tick();
                if (bus.dec_start === 1'b1) starts++;
                n_checks++;
                if (bus.dec_start !== 1'b0 || bus.grant_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_hold[%0d.%0d] got start=%0d vld=%0d exp start=0 vld=1",
                             f, c, bus.dec_start, bus.grant_vld);
                end
            end
            bus.dec_done = 1'b1;
            tick();
            bus.dec_done = 1'b0;
            n_checks++; if (bus.grant_vld !== 1'b0) begin n_fail++; $display("FAIL rr_done_drop[%0d] got=%0d exp=0", f, bus.grant_vld); end
            tick();
            if (f == 4) bus.req = 4'b0000;
            n_checks++; if (bus.dec_start !== 1'b0 || bus.grant_vld !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d] got start=%0d vld=%0d exp 0 0", f, bus.dec_start, bus.grant_vld); end
        end
        n_checks++; if (starts != 5) begin n_fail++; $display("FAIL rr_start_count got=%0d exp=5", starts); end
    endtask

    task automatic test_sparse();
        bit seen;
        logic [1:0] id;
        bus.req = 4'b0101;
        run_frame(1, seen, id);
        n_checks++; if (!seen || id !== 2'd2) begin n_fail++; $display("FAIL sparse_first got seen=%0d id=%0d exp seen=1 id=2", seen, id); end
        run_frame(1, seen, id);
        n_checks++; if (!seen || id !== 2'd0) begin n_fail++; $display("FAIL sparse_second got seen=%0d id=%0d exp seen=1 id=0", seen, id); end
        bus.port_en = 4'b0001; bus.req = 4'b1111;
        for (int f = 0; f < 3; f++) begin
            run_frame(1, seen, id);
            n_checks++; if (!seen || id !== 2'd0) begin n_fail++; $display("FAIL mask_only0[%0d] got seen=%0d id=%0d exp seen=1 id=0", f, seen, id); end
        end
        bus.req = 4'b0000; bus.port_en = 4'b1111;
    endtask

    task automatic test_ready();
        bus.req = 4'b0100; bus.dec_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (bus.grant_vld !== 1'b0 || bus.dec_start !== 1'b0) begin n_fail++; $display("FAIL not_ready[%0d] got vld=%0d start=%0d exp 0 0", c, bus.grant_vld, bus.dec_start); end
        end
        bus.dec_ready = 1'b1;
        tick();
        n_checks++; if (bus.dec_start !== 1'b1 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL ready_rise got start=%0d id=%0d exp start=1 id=2", bus.dec_start, bus.grant_id); end
        bus.req = 4'b0000; bus.dec_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL req_drop_hold[%0d] got vld=%0d id=%0d exp vld=1 id=2", c, bus.grant_vld, bus.grant_id); end
        end
        bus.dec_done = 1'b1;
        tick();
        bus.dec_done = 1'b0;
        n_checks++; if (bus.grant_vld !== 1'b0 || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL req_drop_done got vld=%0d id=%0d exp vld=0 id=2", bus.grant_vld, bus.grant_id); end
        tick();
        bus.dec_ready = 1'b1;
    endtask

    task automatic test_watchdog();
        bus.req = 4'b0011;
        tick();
        n_checks++; if (bus.dec_start !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL wd_grant got start=%0d id=%0d exp start=1 id=0", bus.dec_start, bus.grant_id); end
        for (int k = 1; k < 16; k++) begin
            tick();
            n_checks++; if (bus.dec_abort !== 1'b0 || bus.grant_vld !== 1'b1) begin n_fail++; $display("FAIL wd_early[%0d] got abort=%0d vld=%0d exp 0 1", k, bus.dec_abort, bus.grant_vld); end
        end
        tick();
        n_checks++; if (bus.dec_abort !== 1'b1 || bus.grant_vld !== 1'b0 || bus.tmo_cnt !== 8'd1) begin n_fail++; $display("FAIL wd_expire got abort=%0d vld=%0d tmo=%0d exp 1 0 1", bus.dec_abort, bus.grant_vld, bus.tmo_cnt); end
        tick();
        n_checks++; if (bus.dec_abort !== 1'b0) begin n_fail++; $display("FAIL wd_abort_width got=%0d exp=0", bus.dec_abort); end
        tick();
        n_checks++; if (bus.dec_start !== 1'b1 || bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL wd_next_port got start=%0d id=%0d exp start=1 id=1", bus.dec_start, bus.grant_id); end
        repeat (15) tick();
        bus.dec_done = 1'b1;
        tick();
        bus.dec_done = 1'b0;
        n_checks++; if (bus.dec_abort !== 1'b0 || bus.grant_vld !== 1'b0 || bus.tmo_cnt !== 8'd1) begin n_fail++; $display("FAIL wd_done_wins got abort=%0d vld=%0d tmo=%0d exp 0 0 1", bus.dec_abort, bus.grant_vld, bus.tmo_cnt); end
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL wd_err_cnt got=%0d exp=0", bus.err_cnt); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_err_sat();
        bit seen;
        logic [1:0] id;
        int starts;
        starts = 0;
        bus.req = 4'b1111; bus.dec_err = 1'b1;
        for (int f = 0; f < 10; f++) begin
            run_frame(0, seen, id);
            if (seen) starts++;
        end
        n_checks++; if (bus.err_cnt !== 8'd10) begin n_fail++; $display("FAIL err_cnt_10 got=%0d exp=10", bus.err_cnt); end
        bus.req = 4'b0000;
        tick();
        bus.dec_done = 1'b1;
        tick();
        bus.dec_done = 1'b0;
        tick();
        n_checks++; if (bus.err_cnt !== 8'd10 || bus.grant_vld !== 1'b0) begin n_fail++; $display("FAIL err_idle_done got err=%0d vld=%0d exp err=10 vld=0", bus.err_cnt, bus.grant_vld); end
        bus.req = 4'b1111;
        run_frame(3, seen, id);
        if (seen) starts++;
        n_checks++; if (bus.err_cnt !== 8'd11) begin n_fail++; $display("FAIL err_once_per_frame got=%0d exp=11", bus.err_cnt); end
        for (int f = 0; f < 289; f++) begin
            run_frame(0, seen, id);
            if (seen) starts++;
        end
        n_checks++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate got=%0d exp=255", bus.err_cnt); end
        n_checks++; if (starts != 300) begin n_fail++; $display("FAIL err_frame_count got=%0d exp=300", starts); end
        n_checks++; if (bus.tmo_cnt !== 8'd1) begin n_fail++; $display("FAIL err_tmo_kept got=%0d exp=1", bus.tmo_cnt); end
        bus.req = 4'b0000; bus.dec_err = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit abort_seen;
        logic [1:0] id;
        bus.req = 4'b1111;
        wait_start(20, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_grant got seen=0 exp seen=1"); end
        tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus.grant_vld !== 1'b0 || bus.dec_abort !== 1'b0 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_reset got vld=%0d abort=%0d id=%0d exp 0 0 0", bus.grant_vld, bus.dec_abort, bus.grant_id); end
        n_checks++; if (bus.err_cnt !== 8'd0 || bus.tmo_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_cnt got err=%0d tmo=%0d exp 0 0", bus.err_cnt, bus.tmo_cnt); end
        rst = 1'b0; bus.req = 4'b0000;
        abort_seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.dec_abort !== 1'b0 || bus.grant_vld !== 1'b0) abort_seen = 1'b1;
        end
        n_checks++; if (abort_seen) begin n_fail++; $display("FAIL mid_no_abort got activity=1 exp activity=0"); end
        bus.req = 4'b1111;
        run_frame(1, seen, id);
        n_checks++; if (!seen || id !== 2'd0) begin n_fail++; $display("FAIL mid_rr_reset got seen=%0d id=%0d exp seen=1 id=0", seen, id); end
        bus.req = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.port_en = 4'd0; bus.req = 4'd0; bus.dec_ready = 1'b0;
        bus.dec_done = 1'b0; bus.dec_err = 1'b0;
        test_reset();
        test_round_robin();
        test_sparse();
        test_ready();
        test_watchdog();
        test_err_sat();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
